// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester op/response channels plus the registered ALU port of the shared-ALU arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 6
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*WIDTH-1:0]  req_num1;
    logic [2*WIDTH-1:0]  req_num2;
    logic [2*CTRL_W-1:0] req_ctrl;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [WIDTH-1:0]    rsp_res;
    logic                rsp_zero;
    logic [WIDTH-1:0]    alu_num1;
    logic [WIDTH-1:0]    alu_num2;
    logic [CTRL_W-1:0]   alu_ctrl;
    logic [WIDTH-1:0]    alu_res;
    logic                alu_zero;
    logic                busy;

    modport slave (
        input  req_valid, req_num1, req_num2, req_ctrl, rsp_ready, alu_res, alu_zero,
        output req_ready, rsp_valid, rsp_res, rsp_zero, alu_num1, alu_num2, alu_ctrl, busy
    );

    modport master (
        output req_valid, req_num1, req_num2, req_ctrl, rsp_ready, alu_res, alu_zero,
        input  req_ready, rsp_valid, rsp_res, rsp_zero, alu_num1, alu_num2, alu_ctrl, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin time-sharing of one combinational ALU between two requesters,
// with registered operands, a programmable settle time and a held response.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 6,
    parameter int SETTLE = 1
) (
    input logic clk,
    input logic rst_n,
    alu_share_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    logic [1:0]        state;
    logic              last_grant;
    logic              owner;
    logic [3:0]        cnt;
    logic              grant;
    logic              take;
    logic [1:0]        rsp_valid;
    logic [WIDTH-1:0]  rsp_res;
    logic              rsp_zero;
    logic [WIDTH-1:0]  alu_num1;
    logic [WIDTH-1:0]  alu_num2;
    logic [CTRL_W-1:0] alu_ctrl;

    // Prefer the requester that did not win last time; fall back to whichever is valid.
    assign grant = bus.req_valid[~last_grant] ? ~last_grant : last_grant;
    assign take  = rst_n && state == IDLE && |bus.req_valid;

    assign bus.req_ready = take ? 2'(2'b01 << grant) : 2'b00;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_res   = rsp_res;
    assign bus.rsp_zero  = rsp_zero;
    assign bus.alu_num1  = alu_num1;
    assign bus.alu_num2  = alu_num2;
    assign bus.alu_ctrl  = alu_ctrl;
    assign bus.busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            rsp_valid  <= '0;
            rsp_res    <= '0;
            rsp_zero   <= 1'b0;
            alu_num1   <= '0;
            alu_num2   <= '0;
            alu_ctrl   <= '0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    alu_num1 <= grant ? bus.req_num1[2*WIDTH-1:WIDTH]   : bus.req_num1[WIDTH-1:0];
                    alu_num2 <= grant ? bus.req_num2[2*WIDTH-1:WIDTH]   : bus.req_num2[WIDTH-1:0];
                    alu_ctrl <= grant ? bus.req_ctrl[2*CTRL_W-1:CTRL_W] : bus.req_ctrl[CTRL_W-1:0];
                    owner    <= grant;
                    cnt      <= CNT_LOAD;
                    state    <= EXEC;
                end
                EXEC: if (cnt == '0) begin
                    rsp_res   <= bus.alu_res;
                    rsp_zero  <= bus.alu_zero;
                    rsp_valid <= 2'(2'b01 << owner);
                    state     <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (bus.rsp_ready[owner]) begin
                    rsp_valid  <= '0;
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of the shared-ALU arbiter with an xor stub ALU,
// one instance with SETTLE=1 and one with SETTLE=4.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(32), .CTRL_W(6)) ia ();
    alu_share_arbiter_if #(.WIDTH(32), .CTRL_W(6)) ib ();

    assign ia.alu_res  = ia.alu_num1 ^ ia.alu_num2;
    assign ia.alu_zero = ia.alu_res == '0;
    assign ib.alu_res  = ib.alu_num1 ^ ib.alu_num2;
    assign ib.alu_zero = ib.alu_res == '0;

    alu_share_arbiter #(.WIDTH(32), .CTRL_W(6), .SETTLE(1)) ua (.clk(clk), .rst_n(rst_n), .bus(ia));
    alu_share_arbiter #(.WIDTH(32), .CTRL_W(6), .SETTLE(4)) ub (.clk(clk), .rst_n(rst_n), .bus(ib));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        ia.req_valid = 2'b11; ia.req_num1 = '0; ia.req_num2 = '0; ia.req_ctrl = '0; ia.rsp_ready = '0;
        ib.req_valid = 2'b00; ib.req_num1 = '0; ib.req_num2 = '0; ib.req_ctrl = '0; ib.rsp_ready = '0;
        #3;
        chk("rst_req_ready", 64'(ia.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(ia.rsp_valid), 64'd0);
        chk("rst_busy", 64'(ia.busy), 64'd0);
        chk("rst_alu_ctrl", 64'(ia.alu_ctrl), 64'd0);
        chk("rst_rsp_res", 64'(ia.rsp_res), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ia.req_valid = 2'b00;
        // single op from requester 0
        @(negedge clk);
        ia.req_valid = 2'b01;
        ia.req_num1[31:0] = 32'hFFFFFFF7;
        ia.req_num2[31:0] = 32'h3;
        ia.req_ctrl[5:0] = 6'd9;
        #1;
        chk("t1_req_ready", 64'(ia.req_ready), 64'h1);
        @(negedge clk);
        ia.req_valid = 2'b00;
        #1;
        chk("t1_ready_drop", 64'(ia.req_ready), 64'h0);
        chk("t1_alu_ctrl", 64'(ia.alu_ctrl), 64'd9);
        chk("t1_alu_num1", 64'(ia.alu_num1), 64'hFFFFFFF7);
        chk("t1_busy", 64'(ia.busy), 64'h1);
        chk("t1_rsp_early", 64'(ia.rsp_valid), 64'h0);
        @(negedge clk);
        chk("t1_rsp_valid", 64'(ia.rsp_valid), 64'h1);
        chk("t1_rsp_res", 64'(ia.rsp_res), 64'hFFFFFFF4);
        chk("t1_rsp_zero", 64'(ia.rsp_zero), 64'h0);
        ia.rsp_ready = 2'b01;
        @(negedge clk);
        chk("t1_rsp_done", 64'(ia.rsp_valid), 64'h0);
        chk("t1_idle", 64'(ia.busy), 64'h0);
        ia.rsp_ready = 2'b00;
        // zero flag from requester 1, non-owner rsp_ready ignored
        ia.req_valid = 2'b10;
        ia.req_num1[63:32] = 32'd5;
        ia.req_num2[63:32] = 32'd5;
        ia.req_ctrl[11:6] = 6'd7;
        #1;
        chk("z_req_ready", 64'(ia.req_ready), 64'h2);
        @(negedge clk);
        ia.req_valid = 2'b00;
        @(negedge clk);
        chk("z_rsp_valid", 64'(ia.rsp_valid), 64'h2);
        chk("z_rsp_res", 64'(ia.rsp_res), 64'h0);
        chk("z_rsp_zero", 64'(ia.rsp_zero), 64'h1);
        ia.rsp_ready = 2'b01;
        @(negedge clk);
        chk("z_nonowner", 64'(ia.rsp_valid), 64'h2);
        ia.rsp_ready = 2'b10;
        @(negedge clk);
        chk("z_done", 64'(ia.rsp_valid), 64'h0);
        // both valid, responses always taken: r0,r1,r0,r1 every 3 cycles
        ia.req_valid = 2'b11;
        ia.rsp_ready = 2'b11;
        ia.req_num1 = {32'h20, 32'h10};
        ia.req_num2 = {32'h02, 32'h01};
        ia.req_ctrl = {6'd11, 6'd10};
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("alt%0d_grant", i), 64'(ia.req_ready), (i % 2) ? 64'h2 : 64'h1);
            @(negedge clk);
            chk($sformatf("alt%0d_ctrl", i), 64'(ia.alu_ctrl), (i % 2) ? 64'd11 : 64'd10);
            @(negedge clk);
            chk($sformatf("alt%0d_rsp", i), 64'(ia.rsp_valid), (i % 2) ? 64'h2 : 64'h1);
            chk($sformatf("alt%0d_res", i), 64'(ia.rsp_res), (i % 2) ? 64'h22 : 64'h11);
            @(negedge clk);
        end
        ia.req_valid = 2'b00;
        ia.rsp_ready = 2'b00;
        // back-pressure: r0 holds its response while r1 waits
        @(negedge clk);
        ia.req_valid = 2'b01;
        ia.req_num1 = {32'h30, 32'hAA};
        ia.req_num2 = {32'h03, 32'h0F};
        ia.req_ctrl = {6'd12, 6'd13};
        #1;
        chk("bp_grant0", 64'(ia.req_ready), 64'h1);
        @(negedge clk);
        ia.req_valid = 2'b10;
        #1;
        chk("bp_exec_noready", 64'(ia.req_ready), 64'h0);
        @(negedge clk);
        chk("bp_rsp_valid", 64'(ia.rsp_valid), 64'h1);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("bp%0d_ready", i), 64'(ia.req_ready), 64'h0);
            chk($sformatf("bp%0d_res", i), 64'(ia.rsp_res), 64'hA5);
            chk($sformatf("bp%0d_busy", i), 64'(ia.busy), 64'h1);
            @(negedge clk);
        end
        ia.rsp_ready = 2'b01;
        @(negedge clk);
        #1;
        chk("bp_released", 64'(ia.rsp_valid), 64'h0);
        chk("bp_grant1", 64'(ia.req_ready), 64'h2);
        @(negedge clk);
        ia.req_valid = 2'b00;
        ia.rsp_ready = 2'b10;
        chk("bp_ctrl1", 64'(ia.alu_ctrl), 64'd12);
        @(negedge clk);
        chk("bp_rsp1", 64'(ia.rsp_valid), 64'h2);
        chk("bp_res1", 64'(ia.rsp_res), 64'h33);
        @(negedge clk);
        chk("bp_end", 64'(ia.busy), 64'h0);
        ia.rsp_ready = 2'b00;
        // SETTLE=4: operands steady through EXEC, response 5 edges after accept
        ib.req_valid = 2'b01;
        ib.req_num1[31:0] = 32'h1234;
        ib.req_num2[31:0] = 32'h00FF;
        ib.req_ctrl[5:0] = 6'd5;
        #1;
        chk("s4_grant", 64'(ib.req_ready), 64'h1);
        @(negedge clk);
        ib.req_valid = 2'b00;
        ib.req_num1[31:0] = 32'hDEAD;
        ib.req_ctrl[5:0] = 6'd33;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s4_%0d_rsp", i), 64'(ib.rsp_valid), 64'h0);
            chk($sformatf("s4_%0d_num1", i), 64'(ib.alu_num1), 64'h1234);
            chk($sformatf("s4_%0d_num2", i), 64'(ib.alu_num2), 64'h00FF);
            chk($sformatf("s4_%0d_ctrl", i), 64'(ib.alu_ctrl), 64'd5);
            @(negedge clk);
        end
        chk("s4_rsp_valid", 64'(ib.rsp_valid), 64'h1);
        chk("s4_rsp_res", 64'(ib.rsp_res), 64'h12CB);
        ib.rsp_ready = 2'b01;
        @(negedge clk);
        chk("s4_done", 64'(ib.rsp_valid), 64'h0);
        ib.rsp_ready = 2'b00;
        // async reset mid-EXEC; last_grant is 0 here, so reset must restore r0 priority
        ib.req_valid = 2'b01;
        ib.req_ctrl[5:0] = 6'd7;
        @(posedge clk);
        #2;
        chk("ar_pre_ctrl", 64'(ib.alu_ctrl), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("ar_rsp_valid", 64'(ib.rsp_valid), 64'h0);
        chk("ar_busy", 64'(ib.busy), 64'h0);
        chk("ar_alu_ctrl", 64'(ib.alu_ctrl), 64'h0);
        chk("ar_req_ready", 64'(ib.req_ready), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ib.req_valid = 2'b11;
        #1;
        chk("ar_first_r0", 64'(ib.req_ready), 64'h1);
        @(negedge clk);
        ib.req_valid = 2'b00;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("ar_op_rsp", 64'(ib.rsp_valid), 64'h1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Time-shares one combinational alu_module between two requesters, for example the fetch/branch unit and the execute unit.
- Each requester gets a valid/ready operation channel and a valid/ready response channel.
- Round-robin grant; operands are registered into the ALU; the result is captured after a programmable settle time and held until the winner accepts it.
- Sits between the control path and the alu_module instance.

Parameters:
- WIDTH, 32, operand/result width (num1, num2, res).
- CTRL_W, 6, alu_ctrl width.
- SETTLE, 1, cycles operands are held on the ALU before res/zero are sampled; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: operation from requester i accepted this cycle.
- req_num1  in  2*WIDTH  slice i = num1 of requester i.
- req_num2  in  2*WIDTH  slice i = num2 of requester i.
- req_ctrl  in  2*CTRL_W  slice i = alu_ctrl of requester i.
- rsp_valid  out  2  bit i: result for requester i available.
- rsp_ready  in  2  bit i: requester i consumes the result.
- rsp_res  out  WIDTH  captured result (shared bus; qualified by rsp_valid).
- rsp_zero  out  1  captured zero flag.
- alu_num1  out  WIDTH  to alu_module num1 (registered).
- alu_num2  out  WIDTH  to alu_module num2 (registered).
- alu_ctrl  out  CTRL_W  to alu_module alu_ctrl (registered).
- alu_res  in  WIDTH  from alu_module res.
- alu_zero  in  1  from alu_module zero.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). On assertion:
  - state=IDLE, req_ready=0, rsp_valid=0.
  - rsp_res=0, rsp_zero=0, alu_num1=0, alu_num2=0, alu_ctrl=0.
  - busy=0, last_grant=1 (so requester 0 wins first), settle counter=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = round-robin winner among req_valid. The winner is the requester other than last_grant if it is valid, else the valid one.
  - req_ready[grant]=1 combinationally in the same cycle. At most one req_ready bit is ever high, and only in IDLE.
  - On req_valid&req_ready: latch the slice into alu_num1/alu_num2/alu_ctrl, store owner=grant, load counter=SETTLE-1, go to EXEC.
  - No valid request: remain in IDLE, ALU registers hold their previous values.
- EXEC:
  - Operands are stable on the ALU.
  - Counter decrements each cycle.
  - When counter==0: capture alu_res into rsp_res and alu_zero into rsp_zero, set rsp_valid[owner]=1, go to RESP.
  - EXEC lasts exactly SETTLE cycles.
- RESP:
  - rsp_valid[owner] stays high; rsp_res and rsp_zero are held stable.
  - On rsp_ready[owner]: rsp_valid drops next edge, last_grant=owner, go to IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency: accept edge to rsp_valid rising = SETTLE+1 edges. Minimum issue interval = SETTLE+2 cycles with rsp_ready held high.
- Back-pressure: while in RESP, no new grant is given (req_ready=0 to both), regardless of req_valid.
- Simultaneous requests: strict alternation while both are held valid.
- Single requester: repeatedly granted; last_grant does not block it.
- req_valid withdrawn before ready: no effect, no state change; protocol violation tolerated silently.
- rsp_ready asserted before rsp_valid: ignored.
- Reset mid-EXEC or mid-RESP: the operation is discarded, no response is issued, all outputs return to reset values immediately.
- Width rules: operands pass through unmodified (no sign handling in this block). rsp_res is a bit-exact copy of alu_res at the capture edge.

Test Plan:
- Bench stub ALU: res=num1^num2, zero=(res==0), SETTLE=1.
- Single op, requester 0: num1=32'hFFFFFFF7 (-9), num2=3, ctrl=9 ->
  - req_ready[0] high for 1 cycle; alu_ctrl=9 next edge.
  - rsp_valid[0] high 2 edges after accept, rsp_res=32'hFFFFFFF4, rsp_zero=0.
- Both valid continuously, rsp_ready=2'b11, ctrl 10 on r0 and 11 on r1 -> grants ordered r0,r1,r0,r1; each rsp_valid reaches the correct owner; issue interval 3 cycles.
- Zero flag: num1=num2=5 from requester 1 -> rsp_zero=1, rsp_res=0, rsp_valid=2'b10.
- Back-pressure: rsp_ready[0]=0 for 10 cycles while r1 is valid ->
  - req_ready stays 00; rsp_res stable; busy=1.
  - After release, r1 is granted on the next cycle.
- SETTLE=4 build: accept-to-rsp_valid = 5 edges; alu_num1/alu_num2/alu_ctrl constant throughout EXEC.
- Async reset: rst_n low in mid-EXEC between edges -> rsp_valid=0, busy=0, alu_ctrl=0 immediately; first op after reset is granted to requester 0.
